pes_fpmul_arbiter: RTL and testbench
====================================

PES_FPMUL_ARBITER -- requirements
Module: pes_fpmul_arbiter

Interface
REQ-001 Parameters SHALL be:
- NREQ, default 4: number of requesters (2..8).
- TIMEOUT, default 15: maximum cycles spent in WAIT (1..255).

REQ-002 Ports SHALL be, clock and reset first:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request.
- req_a  in  11*NREQ  operand A of requester i at bits [11*i+10:11*i]; format {sign, exp[5:0] bias 31, man[3:0]}.
- req_b  in  11*NREQ  operand B, same packing.
- req_ready  out  NREQ  one-hot accept; combinational.
- mul_a  out  11  operand A to the shared multiplier.
- mul_b  out  11  operand B to the shared multiplier.
- mul_in_ready  out  1  one-cycle start pulse to the multiplier.
- mul_product  in  11  multiplier result.
- mul_done  in  1  multiplier result-valid.
- rsp_valid  out  NREQ  one-hot, one-cycle response strobe.
- rsp_product  out  11  response product.
- rsp_error  out  1  response was a timeout.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE, req_ready SHALL assert for exactly one requester: the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ. req_ready SHALL be 0 in all other states.
REQ-005 A transfer SHALL occur when req_valid[g] and req_ready[g] are both 1. On a transfer the block SHALL:
- latch g, req_a slice g and req_b slice g;
- set rr_ptr to (g+1) mod NREQ.
REQ-006 After a transfer, the next state SHALL be RESP if either latched operand equals 11'h000, otherwise ISSUE.
- Zero bypass: product 11'h000, rsp_error 0, the multiplier is not started.
REQ-007 ISSUE SHALL last one cycle, assert mul_in_ready=1 with mul_a/mul_b driven from the latched operands, then go to WAIT.
REQ-008 mul_a and mul_b SHALL hold the latched operands from ISSUE through the end of WAIT.
REQ-009 mul_done SHALL be ignored outside WAIT.
REQ-010 In WAIT, a wait counter SHALL start at 0 on entry and increment every cycle.
- mul_done=1: capture mul_product, set error=0, go to RESP.
- Otherwise, when the counter reaches TIMEOUT-1: set product=0, error=1, go to RESP.
- mul_done wins if it coincides with timeout.
REQ-011 RESP SHALL last one cycle:
- rsp_valid[g]=1, with rsp_product and rsp_error valid in that cycle;
- next state IDLE;
- rsp_product and rsp_error hold their values until the next RESP.
REQ-012 Latency, with the transfer at cycle T:
- mul_in_ready at T+1;
- earliest rsp_valid at T+3 (mul_done at T+2);
- zero bypass rsp_valid at T+1.
REQ-013 A new transfer SHALL NOT occur in the RESP cycle; back-to-back grants SHALL be spaced by at least one IDLE cycle.
REQ-014 A requester SHALL hold req_valid and its operands stable until accepted. Deasserting req_valid before acceptance SHALL be legal and SHALL remove it from arbitration.
REQ-015 With a single active requester, it SHALL be granted on every IDLE visit; a requester is never starved while rr_ptr rotates.
REQ-016 The block SHALL NOT modify operand or product bit patterns, except for forcing 11'h000 on zero bypass and on timeout.

Reset
REQ-017 With rst high at a rising edge, the block SHALL enter IDLE and clear rr_ptr, g, wait counter, rsp_product and rsp_error to 0.
REQ-018 During reset, and in the first cycle after it, all outputs SHALL be 0 except req_ready, which follows REQ-004 once rst is low.
REQ-019 Reset asserted mid-transaction in any state SHALL discard the transaction. No rsp_valid is produced for it, and a mul_done arriving afterwards SHALL be ignored.

Verification
REQ-020 Single request: req 0 with a=11'h3E8, b=11'h3E8; multiplier returns 11'h3F8 with mul_done at T+2.
- Response: mul_in_ready at T+1; rsp_valid=4'b0001 at T+3; rsp_product=11'h3F8; rsp_error=0.
REQ-021 Round robin: all four req_valid held high for eight transactions.
- Grant order: 0,1,2,3,0,1,2,3.
- Exactly one rsp_valid bit per transaction, matching its grant.
REQ-022 Zero bypass: req 2 with a=11'h000, b=11'h3F0.
- Response: rsp_valid=4'b0100 at T+1, product 11'h000, mul_in_ready never asserted.
REQ-023 Timeout: mul_done held 0 with TIMEOUT=15.
- Response: rsp_valid 15 cycles after entering WAIT; rsp_error=1; rsp_product=11'h000.
- mul_done at the timeout cycle instead gives error=0.
REQ-024 Reset mid-WAIT: rst pulsed for one cycle during WAIT, then mul_done arrives.
- Response: no rsp_valid; busy=0; the next grant goes to the lowest-index valid requester (rr_ptr=0).

Source files
------------

// File: rtl/pes_fpmul_arbiter.sv
// pes_fpmul_arbiter
// Round-robin arbiter that lets NREQ requesters share one floating-point
// multiplier. A grant is taken in IDLE. Operands are latched and issued to
// the multiplier with a one-cycle start pulse. The block then waits, with a
// timeout, for the result and returns it on a one-hot response strobe.
// Operands equal to 11'h000 skip the multiplier and respond with zero at once.
//
// Handshake: a transfer happens in a cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is combinational, is one-hot, and is
// only offered in IDLE while rst is low. A requester holds req_valid and its
// operands until it is accepted, and it may withdraw at any time before then.
module pes_fpmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [11*NREQ-1:0]   req_a,
    input  logic [11*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [10:0]          mul_a,
    output logic [10:0]          mul_b,
    output logic                 mul_in_ready,
    input  logic [10:0]          mul_product,
    input  logic                 mul_done,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [10:0]          rsp_product,
    output logic                 rsp_error,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NREQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
    localparam logic [7:0]    LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   g_q, g_d;
    logic [10:0]     a_q, a_d;
    logic [10:0]     b_q, b_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [10:0]     prod_q, prod_d;
    logic            err_q, err_d;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW:0]     cand;
    logic [10:0]     a_sel;
    logic [10:0]     b_sel;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && req_valid[cand[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IW-1:0];
            end
        end
    end

    assign a_sel = req_a[11*grant_idx +: 11];
    assign b_sel = req_b[11*grant_idx +: 11];

    // Next-state and output decode; every output and _d defaults first.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        g_d          = g_q;
        a_d          = a_q;
        b_d          = b_q;
        wcnt_d       = wcnt_q;
        prod_d       = prod_q;
        err_d        = err_q;
        req_ready    = '0;
        mul_a        = '0;
        mul_b        = '0;
        mul_in_ready = 1'b0;
        rsp_valid    = '0;

        case (state_q)
            IDLE: begin
                if (grant_found && !rst) begin
                    // The offered grant is always to a valid requester, so
                    // offering it is the same as taking the transfer.
                    req_ready = NREQ'(1) << grant_idx;
                    g_d       = grant_idx;
                    a_d       = a_sel;
                    b_d       = b_sel;
                    rr_ptr_d  = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);
                    if (a_sel == 11'h000 || b_sel == 11'h000) begin
                        // Zero bypass: answer zero without using the multiplier.
                        prod_d  = 11'h000;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                mul_in_ready = 1'b1;
                mul_a        = a_q;
                mul_b        = b_q;
                wcnt_d       = '0;
                state_d      = WAIT;
            end
            WAIT: begin
                mul_a = a_q;
                mul_b = b_q;
                // A result arriving in the final counted cycle beats the timeout.
                if (mul_done) begin
                    prod_d  = mul_product;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (wcnt_q == LAST_CNT) begin
                    prod_d  = 11'h000;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            RESP: begin
                rsp_valid = NREQ'(1) << g_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            g_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wcnt_q   <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            g_q      <= g_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wcnt_q   <= wcnt_d;
            prod_q   <= prod_d;
            err_q    <= err_d;
        end
    end

    assign rsp_product = prod_q;
    assign rsp_error   = err_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pes_fpmul_arbiter.sv
// Directed testbench for pes_fpmul_arbiter (NREQ=4, TIMEOUT=15).
// Each cycle is entered with tick (rising edge + 1ns). Inputs are then driven,
// and outputs are sampled 1ns later, well away from either clock edge.
module tb_pes_fpmul_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 15;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [11*NREQ-1:0]   req_a;
  logic [11*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic [10:0]          mul_a;
  logic [10:0]          mul_b;
  logic                 mul_in_ready;
  logic [10:0]          mul_product;
  logic                 mul_done;
  logic [NREQ-1:0]      rsp_valid;
  logic [10:0]          rsp_product;
  logic                 rsp_error;
  logic                 busy;

  int checks;
  int failures;

  // expected one-hot grants for the round-robin scenario
  logic [NREQ-1:0] exp_q[$];

  pes_fpmul_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
    .req_ready(req_ready),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_in_ready(mul_in_ready),
    .mul_product(mul_product),
    .mul_done(mul_done),
    .rsp_valid(rsp_valid),
    .rsp_product(rsp_product),
    .rsp_error(rsp_error),
    .busy(busy)
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int idx, input logic [10:0] a, input logic [10:0] b);
    req_a[11*idx +: 11] = a;
    req_b[11*idx +: 11] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b0001;
    set_op(0, 11'h3E8, 11'h3E8);
    tick();
    tick();
    settle();
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
    checks++; if (mul_in_ready !== 1'b0) begin failures++; $display("FAIL reset_mul_in_ready got=%b exp=0", mul_in_ready); end
    req_valid = '0;
    rst = 1'b0;
    tick();
    settle();
    checks++; if (rsp_product !== 11'h000) begin failures++; $display("FAIL post_reset_product got=%h exp=000", rsp_product); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL post_reset_error got=%b exp=0", rsp_error); end
    checks++; if (mul_a !== 11'h000 || mul_b !== 11'h000) begin failures++; $display("FAIL post_reset_mul_ops got=%h/%h exp=000/000", mul_a, mul_b); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    set_op(0, 11'h3E8, 11'h3E8);
    settle();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    tick();  // T+1 ISSUE
    req_valid = '0;
    settle();
    checks++; if (mul_in_ready !== 1'b1) begin failures++; $display("FAIL single_issue got=%b exp=1", mul_in_ready); end
    checks++; if (mul_a !== 11'h3E8 || mul_b !== 11'h3E8) begin failures++; $display("FAIL single_ops got=%h/%h exp=3e8/3e8", mul_a, mul_b); end
    checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL single_ready_busy got=%b exp=0000", req_ready); end
    tick();  // T+2 WAIT
    mul_done = 1'b1;
    mul_product = 11'h3F8;
    settle();
    checks++; if (mul_in_ready !== 1'b0) begin failures++; $display("FAIL single_pulse_len got=%b exp=0", mul_in_ready); end
    checks++; if (mul_a !== 11'h3E8) begin failures++; $display("FAIL single_hold_a got=%h exp=3e8", mul_a); end
    tick();  // T+3 RESP
    mul_done = 1'b0;
    mul_product = 11'h000;
    settle();
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_product !== 11'h3F8) begin failures++; $display("FAIL single_product got=%h exp=3f8", rsp_product); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL single_error got=%b exp=0", rsp_error); end
    tick();  // IDLE
    settle();
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_one_cycle got=%b exp=0000", rsp_valid); end
    checks++; if (rsp_product !== 11'h3F8) begin failures++; $display("FAIL single_product_hold got=%h exp=3f8", rsp_product); end
  endtask

  task automatic test_round_robin();
    logic [10:0]     ops[4];
    logic [10:0]     prods[8];
    logic [NREQ-1:0] exp_g;
    int              gi;
    ops = '{11'h101, 11'h202, 11'h303, 11'h404};
    prods = '{11'h011, 11'h122, 11'h233, 11'h344, 11'h455, 11'h566, 11'h677, 11'h788};
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, ops[i], 11'h3C0);
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    req_valid = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp_g = exp_q.pop_front();
      gi = (exp_g == 4'b0001) ? 0 : (exp_g == 4'b0010) ? 1 : (exp_g == 4'b0100) ? 2 : 3;
      settle();
      checks++; if (req_ready !== exp_g) begin failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", t, req_ready, exp_g); end
      tick();  // ISSUE
      settle();
      checks++; if (mul_a !== ops[gi]) begin failures++; $display("FAIL rr_mul_a[%0d] got=%h exp=%h", t, mul_a, ops[gi]); end
      tick();  // WAIT
      mul_done = 1'b1;
      mul_product = prods[t];
      tick();  // RESP
      mul_done = 1'b0;
      settle();
      checks++; if (rsp_valid !== exp_g) begin failures++; $display("FAIL rr_rsp_valid[%0d] got=%b exp=%b", t, rsp_valid, exp_g); end
      checks++; if (rsp_product !== prods[t]) begin failures++; $display("FAIL rr_product[%0d] got=%h exp=%h", t, rsp_product, prods[t]); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL rr_no_grant_in_resp[%0d] got=%b exp=0000", t, req_ready); end
      tick();  // IDLE
    end
    req_valid = '0;
  endtask

  task automatic test_zero_bypass();
    req_valid = 4'b0100;
    set_op(2, 11'h000, 11'h3F0);
    settle();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL zb_grant got=%b exp=0100", req_ready); end
    tick();  // T+1 RESP
    req_valid = '0;
    settle();
    checks++; if (rsp_valid !== 4'b0100) begin failures++; $display("FAIL zb_rsp_valid got=%b exp=0100", rsp_valid); end
    checks++; if (rsp_product !== 11'h000) begin failures++; $display("FAIL zb_product got=%h exp=000", rsp_product); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL zb_error got=%b exp=0", rsp_error); end
    checks++; if (mul_in_ready !== 1'b0) begin failures++; $display("FAIL zb_no_issue got=%b exp=0", mul_in_ready); end
    tick();  // IDLE
    settle();
    checks++; if (mul_in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL zb_idle got=%b/%b exp=0/0", mul_in_ready, busy); end
    // zero in operand B only
    req_valid = 4'b0010;
    set_op(1, 11'h3E8, 11'h000);
    tick();  // RESP
    req_valid = '0;
    settle();
    checks++; if (rsp_valid !== 4'b0010 || mul_in_ready !== 1'b0) begin failures++; $display("FAIL zb_b_rsp got=%b/%b exp=0010/0", rsp_valid, mul_in_ready); end
    tick();
  endtask

  task automatic test_timeout_coincide();
    req_valid = 4'b1000;
    set_op(3, 11'h3C0, 11'h3C0);
    settle();
    checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL toc_grant got=%b exp=1000", req_ready); end
    tick();  // ISSUE: a done here must be ignored
    req_valid = '0;
    mul_done = 1'b1;
    mul_product = 11'h7FF;
    settle();
    checks++; if (mul_in_ready !== 1'b1) begin failures++; $display("FAIL toc_issue got=%b exp=1", mul_in_ready); end
    tick();  // WAIT entry, count 0
    mul_done = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      settle();
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL toc_wait[%0d] got=%b/%b exp=0000/1", i, rsp_valid, busy); end
      tick();
    end
    mul_done = 1'b1;  // final WAIT cycle
    mul_product = 11'h3AB;
    tick();  // RESP
    mul_done = 1'b0;
    settle();
    checks++; if (rsp_valid !== 4'b1000) begin failures++; $display("FAIL toc_rsp_valid got=%b exp=1000", rsp_valid); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL toc_error got=%b exp=0", rsp_error); end
    checks++; if (rsp_product !== 11'h3AB) begin failures++; $display("FAIL toc_product got=%h exp=3ab", rsp_product); end
    tick();
  endtask

  task automatic test_timeout();
    req_valid = 4'b0001;
    set_op(0, 11'h3C0, 11'h3C1);
    settle();
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL to_grant got=%b exp=0001", req_ready); end
    tick();  // ISSUE
    req_valid = '0;
    tick();  // WAIT entry
    for (int i = 0; i < TIMEOUT; i++) begin
      settle();
      checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL to_wait[%0d] got=%b exp=0000", i, rsp_valid); end
      tick();
    end
    settle();  // 15 cycles after WAIT entry
    checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL to_rsp_valid got=%b exp=0001", rsp_valid); end
    checks++; if (rsp_error !== 1'b1) begin failures++; $display("FAIL to_error got=%b exp=1", rsp_error); end
    checks++; if (rsp_product !== 11'h000) begin failures++; $display("FAIL to_product got=%h exp=000", rsp_product); end
    tick();
    settle();
    checks++; if (rsp_error !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL to_hold got=%b/%b exp=1/0000", rsp_error, rsp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    req_valid = 4'b0100;
    set_op(2, 11'h3E8, 11'h3E8);
    settle();
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmw_grant got=%b exp=0100", req_ready); end
    tick();  // ISSUE
    req_valid = '0;
    tick();  // WAIT
    rst = 1'b1;
    tick();  // reset taken
    settle();
    checks++; if (busy !== 1'b0 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmw_in_reset got=%b/%b exp=0/0000", busy, rsp_valid); end
    rst = 1'b0;
    mul_done = 1'b1;
    mul_product = 11'h7FF;
    req_valid = 4'b1010;
    set_op(1, 11'h155, 11'h2AA);
    set_op(3, 11'h3E8, 11'h3E8);
    settle();
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmw_next_grant got=%b exp=0010", req_ready); end
    checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL rmw_after got=%b/%b exp=0000/0", rsp_valid, busy); end
    checks++; if (rsp_error !== 1'b0 || rsp_product !== 11'h000) begin failures++; $display("FAIL rmw_cleared got=%b/%h exp=0/000", rsp_error, rsp_product); end
    tick();  // ISSUE for requester 1
    req_valid = '0;
    settle();
    checks++; if (mul_in_ready !== 1'b1 || mul_a !== 11'h155) begin failures++; $display("FAIL rmw_issue got=%b/%h exp=1/155", mul_in_ready, mul_a); end
    checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmw_late_done got=%b exp=0000", rsp_valid); end
    mul_done = 1'b0;
    tick();
  endtask

  // main sequence and report
  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    mul_product = '0;
    mul_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_bypass();
    test_timeout_coincide();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
